// File: rtl/dmi_resp_model_if.sv
// ============================================================================
// Module      : dm (package), dmi_resp_model_if (interface)
// Description : DMI request/response types and the bus bundle for the
//               debug-module-interface responder model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dm;

    localparam logic [1:0] DTM_NOP     = 2'd0;
    localparam logic [1:0] DTM_READ    = 2'd1;
    localparam logic [1:0] DTM_WRITE   = 2'd2;

    localparam logic [1:0] DTM_SUCCESS = 2'd0;
    localparam logic [1:0] DTM_FAILED  = 2'd2;
    localparam logic [1:0] DTM_BUSY    = 2'd3;

    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

interface dmi_resp_model_if;

    logic          dmi_req_valid_i;
    logic          dmi_req_ready_o;
    dm::dmi_req_t  dmi_req_i;
    logic          dmi_resp_valid_o;
    logic          dmi_resp_ready_i;
    dm::dmi_resp_t dmi_resp_o;
    logic          busy_i;
    logic [15:0]   req_count_o;

    // Responder side
    modport slave (
        input  dmi_req_valid_i,
        input  dmi_req_i,
        input  dmi_resp_ready_i,
        input  busy_i,
        output dmi_req_ready_o,
        output dmi_resp_valid_o,
        output dmi_resp_o,
        output req_count_o
    );

    // Initiator side
    modport master (
        output dmi_req_valid_i,
        output dmi_req_i,
        output dmi_resp_ready_i,
        output busy_i,
        input  dmi_req_ready_o,
        input  dmi_resp_valid_o,
        input  dmi_resp_o,
        input  req_count_o
    );

endinterface

`default_nettype wire

// File: rtl/dmi_resp_model.sv
// ============================================================================
// Module      : dmi_resp_model
// Description : DMI responder with a small register file, fixed response
//               latency, BUSY injection and an accepted-request counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmi_resp_model #(
    parameter int NUM_REGS = 32,
    parameter int LATENCY  = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    dmi_resp_model_if.slave   dmi
);

    localparam int         IDX_W      = $clog2(NUM_REGS);
    localparam logic [7:0] ADDR_LIMIT = 8'(NUM_REGS);
    localparam logic [3:0] CNT_INIT   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          ready_q, ready_d;
    logic [3:0]    cnt_q, cnt_d;
    dm::dmi_resp_t resp_q, resp_d;
    logic [15:0]   req_count_q, req_count_d;
    logic [31:0]   regs_q [NUM_REGS];
    logic [31:0]   regs_d [NUM_REGS];

    dm::dmi_req_t     req;
    logic             accept;
    logic             in_range;
    logic [IDX_W-1:0] idx;

    assign req      = dmi.dmi_req_i;
    assign accept   = ready_q & dmi.dmi_req_valid_i;
    assign idx      = req.addr[IDX_W-1:0];
    assign in_range = ({1'b0, req.addr} < ADDR_LIMIT);

    always_comb begin
        state_d     = state_q;
        ready_d     = 1'b0;
        cnt_d       = cnt_q;
        resp_d      = resp_q;
        req_count_d = req_count_q;
        regs_d      = regs_q;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    ready_d     = 1'b0;
                    req_count_d = req_count_q + 16'd1;
                    resp_d      = '0;
                    // Decode and side effects happen once, at acceptance
                    if (dmi.busy_i) begin
                        resp_d.resp = dm::DTM_BUSY;
                    end else begin
                        case (req.op)
                            dm::DTM_NOP: begin
                                resp_d.resp = dm::DTM_SUCCESS;
                            end
                            dm::DTM_READ: begin
                                if (in_range) begin
                                    resp_d.data = regs_q[idx];
                                end else begin
                                    resp_d.resp = dm::DTM_FAILED;
                                end
                            end
                            dm::DTM_WRITE: begin
                                if (in_range) begin
                                    regs_d[idx] = req.data;
                                end else begin
                                    resp_d.resp = dm::DTM_FAILED;
                                end
                            end
                            default: begin
                                resp_d.resp = dm::DTM_FAILED;
                            end
                        endcase
                    end
                    if (LATENCY == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                // Ready is registered, so a new request lands one edge after the handshake
                if (dmi.dmi_resp_ready_i) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            cnt_q       <= 4'd0;
            resp_q      <= '0;
            req_count_q <= 16'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            cnt_q       <= cnt_d;
            resp_q      <= resp_d;
            req_count_q <= req_count_d;
            regs_q      <= regs_d;
        end
    end

    assign dmi.dmi_req_ready_o  = ready_q;
    assign dmi.dmi_resp_valid_o = (state_q == S_RESP);
    assign dmi.dmi_resp_o       = (state_q == S_RESP) ? resp_q : '0;
    assign dmi.req_count_o      = req_count_q;

    a_ready_only_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ready_q |-> (state_q == S_IDLE));

    a_no_ready_with_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(ready_q && dmi.dmi_resp_valid_o));

    a_resp_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (dmi.dmi_resp_valid_o && !dmi.dmi_resp_ready_i) |=>
            (dmi.dmi_resp_valid_o && $stable(dmi.dmi_resp_o)));

endmodule

`default_nettype wire

// File: tb/tb_dmi_resp_model.sv
// ============================================================================
// Module      : tb_dmi_resp_model
// Description : Table-driven, scoreboarded bench for dmi_resp_model at
//               LATENCY=2 (u_dut0) and LATENCY=0 (u_dut1), NUM_REGS=32.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmi_resp_model;

    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
        logic        busy;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rv [2];
    dm::dmi_req_t rq [2];
    logic         rr [2];
    logic         bz [2];

    int           checks = 0;
    int           errors = 0;
    int           exp_cnt [2];
    exp_t         sb [$];
    vec_t         vecs [14];

    dmi_resp_model_if if0 ();
    dmi_resp_model_if if1 ();

    assign if0.dmi_req_valid_i  = rv[0];
    assign if0.dmi_req_i        = rq[0];
    assign if0.dmi_resp_ready_i = rr[0];
    assign if0.busy_i           = bz[0];
    assign if1.dmi_req_valid_i  = rv[1];
    assign if1.dmi_req_i        = rq[1];
    assign if1.dmi_resp_ready_i = rr[1];
    assign if1.busy_i           = bz[1];

    dmi_resp_model #(.NUM_REGS(32), .LATENCY(2)) u_dut0 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .dmi    (if0)
    );

    dmi_resp_model #(.NUM_REGS(32), .LATENCY(0)) u_dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .dmi    (if1)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic f_ready(input int s);
        return (s != 0) ? if1.dmi_req_ready_o : if0.dmi_req_ready_o;
    endfunction

    function automatic logic f_valid(input int s);
        return (s != 0) ? if1.dmi_resp_valid_o : if0.dmi_resp_valid_o;
    endfunction

    function automatic dm::dmi_resp_t f_resp(input int s);
        return (s != 0) ? if1.dmi_resp_o : if0.dmi_resp_o;
    endfunction

    function automatic logic [15:0] f_count(input int s);
        return (s != 0) ? if1.req_count_o : if0.req_count_o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic sb_check(input string tag, input int s);
        exp_t e;
        dm::dmi_resp_t r;
        if (sb.size() == 0) begin
            fail_timeout({tag, "_sb_empty"});
        end else begin
            e = sb.pop_front();
            r = f_resp(s);
            check({tag, "_resp"}, 64'(r.resp), 64'(e.resp));
            check({tag, "_data"}, 64'(r.data), 64'(e.data));
        end
    endtask

    // One complete request/response; latency counted with the accept edge as edge 1
    task automatic do_txn(input string tag, input int s, input vec_t v, input int exp_lat);
        int n;
        @(negedge clk);
        rq[s] = '{addr: v.addr, op: v.op, data: v.data};
        bz[s] = v.busy;
        rv[s] = 1'b1;
        n = 0;
        while (!f_ready(s) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!f_ready(s)) begin
            fail_timeout({tag, "_accept"});
            rv[s] = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back('{resp: v.exp_resp, data: v.exp_data});
        exp_cnt[s]++;
        #1;
        rv[s] = 1'b0;
        bz[s] = 1'b0;
        rq[s] = '0;
        if (exp_lat > 1) begin
            check({tag, "_idle_resp_zero"}, 64'(f_resp(s)), 64'd0);
        end
        n = 1;
        while (!f_valid(s) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!f_valid(s)) begin
            fail_timeout({tag, "_resp_valid"});
        end else begin
            check({tag, "_latency"}, 64'(n), 64'(exp_lat));
            sb_check(tag, s);
            @(posedge clk);
            #1;
            check({tag, "_count"}, 64'(f_count(s)), 64'(exp_cnt[s]));
        end
    endtask

    initial begin
        exp_t held;
        int   n;
        logic acc;

        vecs[0]  = '{7'd5,   dm::DTM_WRITE, 32'hDEADBEEF, 1'b0, dm::DTM_SUCCESS, 32'h0};
        vecs[1]  = '{7'd5,   dm::DTM_READ,  32'h0,        1'b0, dm::DTM_SUCCESS, 32'hDEADBEEF};
        vecs[2]  = '{7'h40,  dm::DTM_READ,  32'h0,        1'b0, dm::DTM_FAILED,  32'h0};
        vecs[3]  = '{7'd1,   2'd3,          32'hFFFFFFFF, 1'b0, dm::DTM_FAILED,  32'h0};
        vecs[4]  = '{7'd1,   dm::DTM_READ,  32'h0,        1'b0, dm::DTM_SUCCESS, 32'h0};
        vecs[5]  = '{7'd3,   dm::DTM_WRITE, 32'h1234,     1'b1, dm::DTM_BUSY,    32'h0};
        vecs[6]  = '{7'd3,   dm::DTM_READ,  32'h0,        1'b0, dm::DTM_SUCCESS, 32'h0};
        vecs[7]  = '{7'd9,   dm::DTM_NOP,   32'h55,       1'b0, dm::DTM_SUCCESS, 32'h0};
        vecs[8]  = '{7'd31,  dm::DTM_WRITE, 32'hA5A5A5A5, 1'b0, dm::DTM_SUCCESS, 32'h0};
        vecs[9]  = '{7'd31,  dm::DTM_READ,  32'h0,        1'b0, dm::DTM_SUCCESS, 32'hA5A5A5A5};
        vecs[10] = '{7'd32,  dm::DTM_WRITE, 32'h1,        1'b0, dm::DTM_FAILED,  32'h0};
        vecs[11] = '{7'd0,   dm::DTM_READ,  32'h0,        1'b0, dm::DTM_SUCCESS, 32'h0};
        vecs[12] = '{7'd31,  dm::DTM_READ,  32'h0,        1'b1, dm::DTM_BUSY,    32'h0};
        vecs[13] = '{7'd31,  dm::DTM_READ,  32'h0,        1'b0, dm::DTM_SUCCESS, 32'hA5A5A5A5};

        for (int s = 0; s < 2; s++) begin
            rv[s] = 1'b0;
            rq[s] = '0;
            rr[s] = 1'b1;
            bz[s] = 1'b0;
            exp_cnt[s] = 0;
        end

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  64'(if0.dmi_req_ready_o),  64'd0);
        check("rst_valid",  64'(if0.dmi_resp_valid_o), 64'd0);
        check("rst_resp",   64'(if0.dmi_resp_o),       64'd0);
        check("rst_count",  64'(if0.req_count_o),      64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_ready0", 64'(if0.dmi_req_ready_o), 64'd1);
        check("rel_ready1", 64'(if1.dmi_req_ready_o), 64'd1);

        // Table-driven vectors on LATENCY=2
        for (int i = 0; i < 14; i++) begin
            do_txn($sformatf("vec%0d", i), 0, vecs[i], 3);
        end

        // Response held for 10 cycles while a second request is offered
        rr[0] = 1'b0;
        @(negedge clk);
        rq[0] = '{addr: 7'd5, op: dm::DTM_READ, data: 32'h0};
        rv[0] = 1'b1;
        n = 0;
        while (!f_ready(0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        held = '{resp: dm::DTM_SUCCESS, data: 32'hDEADBEEF};
        sb.push_back(held);
        exp_cnt[0]++;
        #1;
        rq[0] = '{addr: 7'd5, op: dm::DTM_WRITE, data: 32'h0};
        n = 1;
        while (!f_valid(0) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!f_valid(0)) begin
            fail_timeout("hold_resp_valid");
        end
        for (int k = 0; k < 10; k++) begin
            check("hold_valid", 64'(if0.dmi_resp_valid_o), 64'd1);
            check("hold_resp",  64'(if0.dmi_resp_o), 64'({held.data, held.resp}));
            check("hold_ready", 64'(if0.dmi_req_ready_o), 64'd0);
            check("hold_count", 64'(if0.req_count_o), 64'(exp_cnt[0]));
            @(posedge clk);
            #1;
        end
        rv[0] = 1'b0;
        rr[0] = 1'b1;
        sb_check("hold", 0);
        @(posedge clk);
        #1;
        check("hold_after_valid", 64'(if0.dmi_resp_valid_o), 64'd0);
        check("hold_after_ready", 64'(if0.dmi_req_ready_o), 64'd1);
        check("hold_after_count", 64'(if0.req_count_o), 64'(exp_cnt[0]));
        do_txn("hold_readback", 0, '{7'd5, dm::DTM_READ, 32'h0, 1'b0, dm::DTM_SUCCESS, 32'hDEADBEEF}, 3);

        // LATENCY=0: setup writes, then back-to-back reads
        do_txn("l0_w4", 1, '{7'd4, dm::DTM_WRITE, 32'h44, 1'b0, dm::DTM_SUCCESS, 32'h0}, 1);
        do_txn("l0_w6", 1, '{7'd6, dm::DTM_WRITE, 32'h66, 1'b0, dm::DTM_SUCCESS, 32'h0}, 1);
        @(negedge clk);
        rv[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rq[1] = '{addr: (((k / 2) % 2) != 0) ? 7'd6 : 7'd4, op: dm::DTM_READ, data: 32'h0};
            acc = f_ready(1) & rv[1];
            check("b2b_ready", 64'(f_ready(1)), 64'((k % 2) == 0));
            if (acc) begin
                sb.push_back('{resp: dm::DTM_SUCCESS,
                               data: (((k / 2) % 2) != 0) ? 32'h66 : 32'h44});
                exp_cnt[1]++;
            end
            @(posedge clk);
            #1;
            check("b2b_valid", 64'(f_valid(1)), 64'((k % 2) == 0));
            if (f_valid(1)) begin
                sb_check("b2b", 1);
            end
            @(negedge clk);
        end
        rv[1] = 1'b0;
        check("b2b_count", 64'(if1.req_count_o), 64'(exp_cnt[1]));

        // Reset while a WRITE is waiting for its response
        @(negedge clk);
        rq[0] = '{addr: 7'd2, op: dm::DTM_WRITE, data: 32'hCAFE};
        rv[0] = 1'b1;
        n = 0;
        while (!f_ready(0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        rv[0] = 1'b0;
        check("wait_valid", 64'(if0.dmi_resp_valid_o), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(if0.dmi_resp_valid_o), 64'd0);
        check("arst_ready", 64'(if0.dmi_req_ready_o),  64'd0);
        check("arst_count", 64'(if0.req_count_o),      64'd0);
        check("arst_resp",  64'(if0.dmi_resp_o),       64'd0);
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        sb.delete();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("inrst_valid", 64'(if0.dmi_resp_valid_o), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("postrst_valid", 64'(if0.dmi_resp_valid_o), 64'd0);
            check("postrst_ready", 64'(if0.dmi_req_ready_o), 64'd1);
        end
        do_txn("postrst_read2", 0, '{7'd2, dm::DTM_READ, 32'h0, 1'b0, dm::DTM_SUCCESS, 32'h0}, 3);
        check("postrst_count", 64'(if0.req_count_o), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
